// File: rtl/photon_pulse_gen.sv
// Programmable photon-pulse emulator: bursts of fixed-width pulses locked to a free-running sync
// period. Define PHOTON_GEN_JITTER_EN to add LFSR-driven jitter (0..7 clocks) to each LOW gap.
module photon_pulse_gen #(
  parameter int unsigned SYNC_PERIOD_CLKS = 1600000,
  parameter int unsigned PULSE_WIDTH      = 4,
  parameter int unsigned CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [CNT_W-1:0] cfg_spacing,
  output logic             pulse_out,
  output logic             sync_out,
  output logic             frame_done,
  output logic [CNT_W-1:0] pulses_sent,
  output logic             overrun
);

  localparam int unsigned PW = $clog2(SYNC_PERIOD_CLKS);
  // Edge counter needs headroom above the spacing field for the clamp and jitter.
  localparam int unsigned EW = CNT_W + 4;

  localparam logic [PW-1:0] PLast    = PW'(SYNC_PERIOD_CLKS - 1);
  localparam logic [PW-1:0] PHalf    = PW'(SYNC_PERIOD_CLKS / 2);
  localparam logic [EW-1:0] WidthE   = EW'(PULSE_WIDTH);
  localparam logic [EW-1:0] MinSpace = EW'(PULSE_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StWait} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic             sync_q, sync_d;
  logic             fd_q, fd_d;
  logic [CNT_W-1:0] sent_out_q, sent_out_d;
  logic             ovr_q, ovr_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [EW-1:0]    e_q, e_d;
  logic [CNT_W-1:0] cnt_sh_q, cnt_sh_d;
  logic [CNT_W-1:0] sp_sh_q, sp_sh_d;

  logic             p_start, p_end, more_pulses, start_pulse;
  logic [EW-1:0]    sp_ext, sp_clamp, sp_target, jitter;

`ifdef PHOTON_GEN_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (start_pulse) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign jitter = EW'(lfsr_q[2:0]);
`else
  assign jitter = '0;
`endif

  always_comb begin
    p_start     = (p_q == '0);
    p_end       = (p_q == PLast);
    p_d         = p_end ? '0 : p_q + 1'b1;
    sync_d      = (p_q < PHalf);
    fd_d        = p_end;
    cnt_sh_d    = p_start ? cfg_count : cnt_sh_q;
    sp_sh_d     = p_start ? cfg_spacing : sp_sh_q;
    sp_ext      = EW'(sp_sh_q);
    sp_clamp    = (sp_ext < MinSpace) ? MinSpace : sp_ext;
    sp_target   = sp_clamp + jitter;
    more_pulses = (sent_q < cnt_sh_q);

    state_d     = state_q;
    sent_d      = sent_q;
    e_d         = e_q;
    sent_out_d  = sent_out_q;
    ovr_d       = ovr_q;
    start_pulse = 1'b0;

    if (p_end) begin
      // Period end overrides every state; a burst that still owes pulses is an overrun.
      sent_out_d = sent_q;
      state_d    = StIdle;
      sent_d     = '0;
      e_d        = '0;
      if ((state_q == StHigh || state_q == StLow) && more_pulses) ovr_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Decision is made in the capture cycle, so use the live config.
          if (p_start && en) begin
            if (cfg_count != '0) start_pulse = 1'b1;
            else                 state_d = StWait;
          end
        end
        StHigh: begin
          if (!en) begin
            state_d = StWait;
          end else begin
            e_d = e_q + 1'b1;
            if (e_q >= WidthE) state_d = StLow;
          end
        end
        StLow: begin
          if (!en) begin
            state_d = StWait;
          end else if (e_q >= sp_target) begin
            if (more_pulses) start_pulse = 1'b1;
            else             state_d = StWait;
          end else begin
            e_d = e_q + 1'b1;
          end
        end
        StWait: ;
        default: state_d = StIdle;
      endcase

      if (start_pulse) begin
        state_d = StHigh;
        sent_d  = sent_q + 1'b1;
        e_d     = EW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      p_q        <= '0;
      sync_q     <= 1'b0;
      fd_q       <= 1'b0;
      sent_out_q <= '0;
      ovr_q      <= 1'b0;
      sent_q     <= '0;
      e_q        <= '0;
      cnt_sh_q   <= '0;
      sp_sh_q    <= '0;
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      sync_q     <= sync_d;
      fd_q       <= fd_d;
      sent_out_q <= sent_out_d;
      ovr_q      <= ovr_d;
      sent_q     <= sent_d;
      e_q        <= e_d;
      cnt_sh_q   <= cnt_sh_d;
      sp_sh_q    <= sp_sh_d;
    end
  end

  assign pulse_out   = (state_q == StHigh);
  assign sync_out    = sync_q;
  assign frame_done  = fd_q;
  assign pulses_sent = sent_out_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_photon_pulse_gen.sv
// Self-checking bench for photon_pulse_gen (default build, no jitter) against a per-period
// waveform model built from rising-edge arithmetic.
module tb_photon_pulse_gen;

  localparam int N   = 200;
  localparam int PWD = 4;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [CW-1:0] cfg_count = '0;
  logic [CW-1:0] cfg_spacing = '0;
  logic          pulse_out, sync_out, frame_done, overrun;
  logic [CW-1:0] pulses_sent;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_p     = 0;
  int exp_sent = 0;
  bit exp_ov   = 0;
  bit exp_fd   = 0;

  photon_pulse_gen #(
    .SYNC_PERIOD_CLKS(N),
    .PULSE_WIDTH     (PWD),
    .CNT_W           (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_count  (cfg_count),
    .cfg_spacing(cfg_spacing),
    .pulse_out  (pulse_out),
    .sync_out   (sync_out),
    .frame_done (frame_done),
    .pulses_sent(pulses_sent),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    tb_p = (tb_p + 1) % N;
  endtask

  // One full period starting in the p==0 cycle. Count c, spacing s; en is low from cycle d on
  // (d >= N means never). With scr set the config inputs are scrambled mid-period.
  task automatic run_period(input int c, input int s, input int d, input bit scr, input string tag);
    bit ep [N];
    int se, started, r;
    for (int i = 0; i < N; i++) ep[i] = 1'b0;
    se = (s < PWD + 1) ? PWD + 1 : s;
    started = 0;
    for (int k = 0; k < c; k++) begin
      r = 1 + k * se;
      if (r > N - 1 || r - 1 >= d) break;
      started++;
      for (int j = 0; j < PWD; j++) if (r + j <= N - 1 && r + j <= d) ep[r + j] = 1'b1;
    end
    for (int p = 0; p < N; p++) begin
      if (p == 0) begin
        cfg_count   = CW'(c);
        cfg_spacing = CW'(s);
      end
      if (scr && p == 60) begin
        cfg_count   = CW'($urandom);
        cfg_spacing = CW'($urandom_range(0, 3));
      end
      en = (p < d);
      n_checks++;
      if (pulse_out !== ep[p]) begin
        n_fail++;
        $display("FAIL %s pulse_out p=%0d got %b want %b", tag, p, pulse_out, ep[p]);
      end
      n_checks++;
      if (sync_out !== (p >= 1 && p <= N / 2)) begin
        n_fail++;
        $display("FAIL %s sync_out p=%0d got %b want %b", tag, p, sync_out, (p >= 1 && p <= N / 2));
      end
      n_checks++;
      if (frame_done !== ((p == 0) ? exp_fd : 1'b0)) begin
        n_fail++;
        $display("FAIL %s frame_done p=%0d got %b want %b", tag, p, frame_done,
                 (p == 0) ? exp_fd : 1'b0);
      end
      n_checks++;
      if (pulses_sent !== CW'(exp_sent)) begin
        n_fail++;
        $display("FAIL %s pulses_sent p=%0d got %0d want %0d", tag, p, pulses_sent, exp_sent);
      end
      n_checks++;
      if (overrun !== exp_ov) begin
        n_fail++;
        $display("FAIL %s overrun p=%0d got %b want %b", tag, p, overrun, exp_ov);
      end
      step();
    end
    exp_sent = started;
    exp_fd   = 1'b1;
    if (d >= N && c > started) exp_ov = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({pulse_out, sync_out, frame_done, overrun} !== 4'b0 || pulses_sent !== '0) begin
      n_fail++;
      $display("FAIL %s reset_outputs got pulse=%b sync=%b fd=%b ovr=%b sent=%0d want all 0",
               tag, pulse_out, sync_out, frame_done, overrun, pulses_sent);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n    = 1'b1;
    tb_p     = 0;
    exp_sent = 0;
    exp_ov   = 0;
    exp_fd   = 0;
  endtask

  task automatic test_basic();
    run_period(5, 10, N, 0, "basic");
    run_period(5, 10, N, 0, "basic2");
  endtask

  task automatic test_zero_count();
    run_period(0, 7, N, 0, "zero");
  endtask

  task automatic test_clamp();
    run_period(3, 2, N, 0, "clamp");
  endtask

  task automatic test_en_drop();
    run_period(5, 10, 13, 0, "en_drop");
    run_period(5, 10, N, 0, "en_resume");
  endtask

  task automatic test_truncate();
    run_period(30, 10, N, 0, "truncate");
    run_period(4, 20, N, 0, "sticky");
    run_period(2, 9, N, 0, "sticky2");
  endtask

  task automatic test_random();
    int c, s, d;
    for (int i = 0; i < 10; i++) begin
      c = $urandom_range(0, 45);
      s = $urandom_range(0, 20);
      d = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 2) : N;
      run_period(c, s, d, 1, "random");
    end
  endtask

  task automatic test_reset_mid();
    cfg_count   = CW'(5);
    cfg_spacing = CW'(10);
    en          = 1'b1;
    step();
    step();
    n_checks++;
    if (pulse_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre_reset_pulse got %b want 1", pulse_out);
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    rst_n    = 1'b1;
    tb_p     = 0;
    exp_sent = 0;
    exp_ov   = 0;
    exp_fd   = 0;
    run_period(5, 10, N, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_clamp();
    test_en_drop();
    test_truncate();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
